// File: rtl/flt2fix_converter.sv
// Iterative float16 (1.5.10) to signed fixed 8.8 converter with start/ack handshake.
// Define F2X_ROUND_EN for round-half-even; otherwise the magnitude is truncated toward zero.
module flt2fix_converter (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] flt_in,
  output logic [15:0] fix_out,
  output logic        ack,
  output logic        ovf,
  output logic        inx
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_SHIFT,
    S_ROUND,
    S_DONE
  } state_t;

  state_t      state;
  logic        start_q;
  logic [15:0] flt_q;
  logic [15:0] mag;
  logic [15:0] res;
  logic        guard;
  logic        sticky;
  logic        left;
  logic        res_ovf;
  logic        res_inx;
  logic [3:0]  cnt;

  logic        sgn;
  logic [4:0]  exp_f;
  logic [9:0]  man;
  logic [4:0]  rdiff;
  logic [4:0]  ldiff;
  logic [3:0]  n_dec;
  logic        round_up;
  logic [15:0] mag_rnd;
  logic [15:0] mag_signed;

  assign sgn   = flt_q[15];
  assign exp_f = flt_q[14:10];
  assign man   = flt_q[9:0];

  // Right shifts are capped at 12: beyond that every bit of M already lands in guard/sticky.
  always_comb begin
    rdiff = 5'd17 - exp_f;
    ldiff = exp_f - 5'd17;
    if (exp_f >= 5'd17)
      n_dec = ldiff[3:0];
    else if (exp_f <= 5'd5)
      n_dec = 4'd12;
    else
      n_dec = rdiff[3:0];
  end

  always_comb begin
`ifdef F2X_ROUND_EN
    round_up = guard & (sticky | mag[0]);
`else
    round_up = 1'b0;
`endif
    mag_rnd    = mag + {15'd0, round_up};
    mag_signed = sgn ? (16'd0 - mag_rnd) : mag_rnd;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      start_q <= 1'b0;
      flt_q   <= '0;
      mag     <= '0;
      res     <= '0;
      guard   <= 1'b0;
      sticky  <= 1'b0;
      left    <= 1'b0;
      res_ovf <= 1'b0;
      res_inx <= 1'b0;
      cnt     <= '0;
      fix_out <= '0;
      ack     <= 1'b0;
      ovf     <= 1'b0;
      inx     <= 1'b0;
    end else begin
      start_q <= start;
      ack     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && !start_q) begin
            flt_q <= flt_in;
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          mag     <= {5'd0, 1'b1, man};
          guard   <= 1'b0;
          sticky  <= 1'b0;
          res     <= '0;
          res_ovf <= 1'b0;
          res_inx <= 1'b0;
          if (exp_f == 5'd0) begin
            res_inx <= (man != 10'd0);
            state   <= S_DONE;
          end else if (exp_f == 5'd31) begin
            res_ovf <= 1'b1;
            if (man == 10'd0)
              res <= sgn ? 16'h8000 : 16'h7FFF;
            else
              res_inx <= 1'b1;
            state <= S_DONE;
          end else if (exp_f >= 5'd22) begin
            // -32768 is the one magnitude >= 2^15 that is representable exactly.
            if (exp_f == 5'd22 && man == 10'd0 && sgn) begin
              res <= 16'h8000;
            end else begin
              res     <= sgn ? 16'h8000 : 16'h7FFF;
              res_ovf <= 1'b1;
            end
            state <= S_DONE;
          end else begin
            left  <= (exp_f >= 5'd17);
            cnt   <= n_dec;
            state <= (n_dec == 4'd0) ? S_ROUND : S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (left) begin
            mag <= {mag[14:0], 1'b0};
          end else begin
            {mag, guard} <= {1'b0, mag};
            sticky       <= sticky | guard;
          end
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1)
            state <= S_ROUND;
        end
        S_ROUND: begin
          res     <= mag_signed;
          res_inx <= guard | sticky;
          res_ovf <= 1'b0;
          state   <= S_DONE;
        end
        S_DONE: begin
          fix_out <= res;
          ovf     <= res_ovf;
          inx     <= res_inx;
          ack     <= 1'b1;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
